// File: rtl/haui_arb_pkg.sv
// Shared types and defaults for the haui_asic register-bus arbiter.
// Contents: FSM state and grant enums, counter width, timeout/error defaults.
package haui_arb_pkg;

   localparam int unsigned CNT_W        = 16;
   localparam int unsigned TIMEOUT_DEF  = 255;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_WB = 1'b0,
      GNT_LA = 1'b1
   } arb_grant_t;

endpackage

// File: rtl/haui_arb_timeout.sv
// Loadable watchdog counter shared by the register-bus bridges.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   i_clr            : synchronous clear to zero (highest priority)
//   i_load/i_load_val: load an arbitrary start value
//   i_en             : count up by one
//   i_limit          : compare value
//   o_expired_c      : combinational, count == limit
module haui_arb_timeout #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic [W-1:0] i_limit,
   output logic         o_expired_c
);

   logic [W-1:0] r_count;

   // Clear beats load beats increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_expired_c = (r_count == i_limit);

endmodule

// File: rtl/haui_bus_arbiter.sv
// Round-robin arbiter sharing the haui_asic register bus between the Caravel
// Wishbone slave port and a logic-analyzer host, with a hung-slave watchdog.
// Ports:
//   wb_clk_i, wb_rst_i         : clock, asynchronous active-high reset
//   wbs_*                      : Wishbone slave (window WB_BASE/WB_MASK)
//   la_req_i/we/adr/dat/sel    : LA command, rising edge of la_req_i starts it
//   la_dat_o/la_done_o/la_err_o: LA read data, done pulse, sticky timeout flag
//   bus_*                      : downstream register-bus request/response
//   err_irq_o                  : one-cycle pulse on any timeout
module haui_bus_arbiter
   import haui_arb_pkg::*;
#(
   parameter int unsigned AW       = 16,
   parameter logic [31:0] WB_BASE  = 32'h3000_0000,
   parameter logic [31:0] WB_MASK  = 32'hFFF0_0000,
   parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [31:0]   wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   input  logic [3:0]    wbs_sel_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   input  logic          la_req_i,
   input  logic          la_we_i,
   input  logic [AW-1:0] la_adr_i,
   input  logic [31:0]   la_dat_i,
   input  logic [3:0]    la_sel_i,
   output logic [31:0]   la_dat_o,
   output logic          la_done_o,
   output logic          la_err_o,
   output logic          bus_req_o,
   output logic          bus_we_o,
   output logic [AW-1:0] bus_adr_o,
   output logic [31:0]   bus_dat_o,
   output logic [3:0]    bus_sel_o,
   input  logic [31:0]   bus_dat_i,
   input  logic          bus_rdy_i,
   output logic          err_irq_o
);

   arb_state_t  r_state;
   arb_grant_t  r_last;
   arb_grant_t  r_gnt;
   logic        r_la_req_q;
   logic        r_la_pend;

   logic        w_hit;
   logic        w_wb_pend;
   logic        w_wb_miss;
   logic        w_la_rise;
   logic        w_la_pend;
   logic        w_pick_la;
   logic        w_grant;
   logic        w_expired;
   logic        w_bus_exit;
   logic [31:0] w_rdata;

   assign w_hit     = ((wbs_adr_i & WB_MASK) == WB_BASE);
   // ~wbs_ack_o keeps a request from being seen twice in its own ack cycle.
   assign w_wb_pend = wbs_cyc_i & wbs_stb_i & w_hit & ~wbs_ack_o;
   assign w_wb_miss = wbs_cyc_i & wbs_stb_i & ~w_hit & ~wbs_ack_o;
   // An edge in an IDLE cycle is granted in that same cycle.
   assign w_la_rise = la_req_i & ~r_la_req_q;
   assign w_la_pend = r_la_pend | w_la_rise;
   // On a tie the host that did not win last time takes the bus.
   assign w_pick_la  = w_la_pend & (~w_wb_pend | (r_last == GNT_WB));
   assign w_grant    = (r_state == IDLE) & (w_wb_pend | w_la_pend);
   assign w_bus_exit = (r_state == BUS) & (bus_rdy_i | w_expired);
   assign w_rdata    = bus_rdy_i ? bus_dat_i : ERR_DATA;

   // Watchdog counts only BUS cycles that are neither completing nor expiring.
   haui_arb_timeout #(
      .W (CNT_W)
   ) u_timeout (
      .clk         (wb_clk_i),
      .rst         (wb_rst_i),
      .i_clr       (r_state != BUS),
      .i_en        ((r_state == BUS) & ~bus_rdy_i & ~w_expired),
      .i_load      (1'b0),
      .i_load_val  ('0),
      .i_limit     (CNT_W'(TIMEOUT)),
      .o_expired_c (w_expired)
   );

   // LA edge detect and single-entry pending flag.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_la_req_q <= 1'b0;
         r_la_pend  <= 1'b0;
      end else begin
         r_la_req_q <= la_req_i;
         r_la_pend  <= w_la_pend & ~(w_grant & w_pick_la);
      end
   end

   // Arbitration FSM with registered host and bus outputs.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state   <= IDLE;
         r_last    <= GNT_LA;
         r_gnt     <= GNT_WB;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         la_dat_o  <= '0;
         la_done_o <= 1'b0;
         la_err_o  <= 1'b0;
         bus_req_o <= 1'b0;
         bus_we_o  <= 1'b0;
         bus_adr_o <= '0;
         bus_dat_o <= '0;
         bus_sel_o <= '0;
         err_irq_o <= 1'b0;
      end else begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         la_done_o <= 1'b0;
         err_irq_o <= 1'b0;
         unique case (r_state)
            IDLE: begin
               // Out-of-window WB access: zero-data ack, no bus slot used.
               if (w_wb_miss) begin
                  wbs_ack_o <= 1'b1;
               end
               if (w_grant) begin
                  bus_req_o <= 1'b1;
                  r_state   <= BUS;
                  if (w_pick_la) begin
                     r_gnt     <= GNT_LA;
                     r_last    <= GNT_LA;
                     la_err_o  <= 1'b0;
                     bus_we_o  <= la_we_i;
                     bus_adr_o <= la_adr_i;
                     bus_dat_o <= la_dat_i;
                     bus_sel_o <= la_sel_i;
                  end else begin
                     r_gnt     <= GNT_WB;
                     r_last    <= GNT_WB;
                     bus_we_o  <= wbs_we_i;
                     bus_adr_o <= wbs_adr_i[AW+1:2];
                     bus_dat_o <= wbs_dat_i;
                     bus_sel_o <= wbs_sel_i;
                  end
               end
            end
            BUS: begin
               if (w_bus_exit) begin
                  bus_req_o <= 1'b0;
                  r_state   <= RESP;
                  if (r_gnt == GNT_LA) begin
                     la_done_o <= 1'b1;
                     la_dat_o  <= w_rdata;
                  end else if (wbs_cyc_i & wbs_stb_i) begin
                     // An aborted WB cycle still finishes downstream, unacked.
                     wbs_ack_o <= 1'b1;
                     wbs_dat_o <= w_rdata;
                  end
                  if (!bus_rdy_i) begin
                     err_irq_o <= 1'b1;
                     if (r_gnt == GNT_LA) begin
                        la_err_o <= 1'b1;
                     end
                  end
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_haui_bus_arbiter.sv
// Scoreboard bench for haui_bus_arbiter: stimulus pushes expected grants and
// completions into queues, a negedge monitor pops and compares them.
module tb_haui_bus_arbiter;

   localparam int unsigned AW = 16;
   localparam int unsigned TO = 4;

   logic          clk;
   logic          wb_rst_i;
   logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [31:0]   wbs_adr_i, wbs_dat_i;
   logic [3:0]    wbs_sel_i;
   logic          wbs_ack_o;
   logic [31:0]   wbs_dat_o;
   logic          la_req_i, la_we_i;
   logic [AW-1:0] la_adr_i;
   logic [31:0]   la_dat_i;
   logic [3:0]    la_sel_i;
   logic [31:0]   la_dat_o;
   logic          la_done_o, la_err_o;
   logic          bus_req_o, bus_we_o;
   logic [AW-1:0] bus_adr_o;
   logic [31:0]   bus_dat_o;
   logic [3:0]    bus_sel_o;
   logic [31:0]   bus_dat_i;
   logic          bus_rdy_i;
   logic          err_irq_o;

   haui_bus_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .la_req_i(la_req_i), .la_we_i(la_we_i), .la_adr_i(la_adr_i),
      .la_dat_i(la_dat_i), .la_sel_i(la_sel_i),
      .la_dat_o(la_dat_o), .la_done_o(la_done_o), .la_err_o(la_err_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
      .bus_dat_o(bus_dat_o), .bus_sel_o(bus_sel_o),
      .bus_dat_i(bus_dat_i), .bus_rdy_i(bus_rdy_i), .err_irq_o(err_irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [52:0] q_gnt[$];   // {adr, we, dat, sel} expected at each bus_req_o rise
   logic [31:0] q_wb[$];    // expected wbs_dat_o per ack
   logic [32:0] q_la[$];    // expected {la_err_o, la_dat_o} per done
   int irq_cnt = 0;
   int req_hi  = 0;
   logic prev_req = 1'b0;
   bit slave_on = 1'b1;
   int slave_lat = 0;
   int slave_cnt = 0;
   int lat_w, lat_l;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_evt(input string name, input string got, input string exp);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %s expected %s", name, got, exp);
   endtask

   // Register slave: rdy after slave_lat BUS cycles, data = 0x1234_5674 + word address.
   always @(negedge clk) begin
      if (wb_rst_i || !bus_req_o) begin
         bus_rdy_i = 1'b0;
         slave_cnt = 0;
      end else begin
         if (slave_on && !bus_rdy_i && slave_cnt >= slave_lat) begin
            bus_rdy_i = 1'b1;
            bus_dat_i = 32'h1234_5674 + {16'h0, bus_adr_o};
         end else begin
            bus_rdy_i = 1'b0;
         end
         slave_cnt++;
      end
   end

   // Monitor: pops expectations whenever the DUT presents a grant or completion.
   always @(negedge clk) begin
      if (wb_rst_i) begin
         prev_req = 1'b0;
      end else begin
         if (wbs_ack_o) begin
            if (q_wb.size() == 0) fail_evt("wb_ack", "ack", "none");
            else check("wb_dat", 64'(wbs_dat_o), 64'(q_wb.pop_front()));
         end else begin
            check("wb_dat_idle", 64'(wbs_dat_o), 64'd0);
         end
         if (la_done_o) begin
            if (q_la.size() == 0) fail_evt("la_done", "done", "none");
            else check("la_err_dat", 64'({la_err_o, la_dat_o}), 64'(q_la.pop_front()));
         end
         if (bus_req_o && !prev_req) begin
            if (q_gnt.size() == 0) fail_evt("bus_grant", "bus_req_o rise", "none");
            else check("bus_cmd", 64'({bus_adr_o, bus_we_o, bus_dat_o, bus_sel_o}),
                       64'(q_gnt.pop_front()));
         end
         prev_req = bus_req_o;
         if (err_irq_o) irq_cnt++;
         if (bus_req_o) req_hi++;
      end
   end

   task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                          output int lat);
      bit got = 1'b0;
      lat = 0;
      @(negedge clk);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = 4'hF;
      while (!got && lat < 100) begin
         @(negedge clk);
         lat++;
         got = wbs_ack_o;
      end
      if (!got) fail_evt("wb_ack_wait", "no ack", "ack");
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_dat_i = '0;
   endtask

   task automatic la_xfer(input logic [AW-1:0] adr, input logic we, input logic [31:0] dat,
                          output int lat);
      bit got = 1'b0;
      lat = 0;
      @(negedge clk);
      la_req_i = 1'b1; la_we_i = we; la_adr_i = adr; la_dat_i = dat; la_sel_i = 4'hF;
      while (!got && lat < 100) begin
         @(negedge clk);
         lat++;
         got = la_done_o;
      end
      if (!got) fail_evt("la_done_wait", "no done", "done");
      la_req_i = 1'b0; la_we_i = 1'b0; la_dat_i = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got hang expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int irq0;
      wb_rst_i = 1'b1;
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
      la_req_i = 0; la_we_i = 0; la_adr_i = '0; la_dat_i = '0; la_sel_i = '0;
      bus_dat_i = '0; bus_rdy_i = 0;
      repeat (3) @(negedge clk);
      check("rst_outputs", 64'({wbs_ack_o, wbs_dat_o, la_done_o, la_err_o, bus_req_o, err_irq_o}), 64'd0);
      check("rst_la_dat", 64'(la_dat_o), 64'd0);
      check("rst_bus_cmd", 64'({bus_we_o, bus_adr_o, bus_dat_o, bus_sel_o}), 64'd0);
      wb_rst_i = 1'b0;
      repeat (2) @(negedge clk);

      // Simultaneous WB write and LA write from reset: WB first.
      q_gnt.push_back({16'h0010, 1'b1, 32'hCAFE_0001, 4'hF});
      q_gnt.push_back({16'h0020, 1'b1, 32'h0000_BEEF, 4'hF});
      q_wb.push_back(32'h1234_5684);
      q_la.push_back({1'b0, 32'h1234_5694});
      fork
         wb_xfer(32'h3000_0040, 1'b1, 32'hCAFE_0001, lat_w);
         la_xfer(16'h0020, 1'b1, 32'h0000_BEEF, lat_l);
      join
      check("pair0_wb_lat", 64'(lat_w), 64'd2);
      check("pair0_la_lat", 64'(lat_l), 64'd5);

      // Three contested read pairs: grants alternate WB, LA.
      for (int i = 0; i < 3; i++) begin
         q_gnt.push_back({16'h0040 + 16'(i), 1'b0, 32'h0, 4'hF});
         q_gnt.push_back({16'h0080 + 16'(i), 1'b0, 32'h0, 4'hF});
         q_wb.push_back(32'h1234_56B4 + 32'(i));
         q_la.push_back({1'b0, 32'h1234_56F4 + 32'(i)});
         fork
            wb_xfer(32'h3000_0100 + 32'(i * 4), 1'b0, 32'h0, lat_w);
            la_xfer(16'h0080 + 16'(i), 1'b0, 32'h0, lat_l);
         join
      end

      // Single WB read, ready in the first BUS cycle.
      q_gnt.push_back({16'h0004, 1'b0, 32'h0, 4'hF});
      q_wb.push_back(32'h1234_5678);
      wb_xfer(32'h3000_0010, 1'b0, 32'h0, lat_w);
      check("wb_read_lat", 64'(lat_w), 64'd2);

      // LA read against a dead slave: timeout after TO counted cycles.
      slave_on = 1'b0;
      irq0 = irq_cnt;
      req_hi = 0;
      q_gnt.push_back({16'h00AA, 1'b0, 32'h0, 4'hF});
      q_la.push_back({1'b1, 32'hDEAD_BEEF});
      la_xfer(16'h00AA, 1'b0, 32'h0, lat_l);
      check("to_lat", 64'(lat_l), 64'd6);
      repeat (3) @(negedge clk);
      check("to_req_cycles", 64'(req_hi), 64'd5);
      check("to_irq_pulses", 64'(irq_cnt - irq0), 64'd1);
      check("to_err_sticky", 64'(la_err_o), 64'd1);
      slave_on = 1'b1;

      // Out-of-window WB access: zero-data ack next cycle, no bus request.
      req_hi = 0;
      q_wb.push_back(32'h0);
      wb_xfer(32'h2000_0000, 1'b0, 32'h0, lat_w);
      check("miss_lat", 64'(lat_w), 64'd1);
      repeat (2) @(negedge clk);
      check("miss_no_req", 64'(req_hi), 64'd0);
      check("miss_err_sticky", 64'(la_err_o), 64'd1);

      // WB abort during BUS: slave finishes, ack suppressed.
      slave_lat = 2;
      q_gnt.push_back({16'h0008, 1'b0, 32'h0, 4'hF});
      @(negedge clk);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0020;
      @(negedge clk);
      check("abort_in_bus", 64'(bus_req_o), 64'd1);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_req_done", 64'(bus_req_o), 64'd0);
      slave_lat = 0;

      // Following LA read is granted immediately and clears the sticky error.
      q_gnt.push_back({16'h0033, 1'b0, 32'h0, 4'hF});
      q_la.push_back({1'b0, 32'h1234_56A7});
      la_xfer(16'h0033, 1'b0, 32'h0, lat_l);
      check("post_abort_lat", 64'(lat_l), 64'd2);

      // Asynchronous reset in the middle of a BUS phase.
      slave_on = 1'b0;
      irq0 = irq_cnt;
      q_gnt.push_back({16'h0001, 1'b0, 32'h0, 4'hF});
      @(negedge clk);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3000_0004;
      @(negedge clk);
      check("rst_mid_in_bus", 64'(bus_req_o), 64'd1);
      #2 wb_rst_i = 1'b1;
      #1;
      check("rst_mid_ctrl", 64'({wbs_ack_o, la_done_o, la_err_o, bus_req_o, err_irq_o}), 64'd0);
      check("rst_mid_data", 64'({bus_adr_o, la_dat_o, wbs_dat_o}), 64'd0);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      repeat (3) @(negedge clk);
      wb_rst_i = 1'b0;
      slave_on = 1'b1;
      repeat (TO + 6) @(negedge clk);
      check("rst_mid_no_irq", 64'(irq_cnt - irq0), 64'd0);
      check("rst_mid_idle", 64'(bus_req_o), 64'd0);

      check("q_gnt_empty", 64'(q_gnt.size()), 64'd0);
      check("q_wb_empty", 64'(q_wb.size()), 64'd0);
      check("q_la_empty", 64'(q_la.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
